// File: rtl/rcb_mp.sv
// Single-port RAM controller: round-robin read channels share the port with a host write queue.
// Reads win over queued writes until the starvation limit forces one write through.
module rcb_mp #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned WQ_DEPTH   = 8,
  parameter int unsigned STARVE_LIM = 16,
  localparam int unsigned CH_W      = (NUM_RD > 1) ? $clog2(NUM_RD) : 1,
  localparam int unsigned LVL_W     = $clog2(WQ_DEPTH + 1),
  localparam int unsigned BE_W      = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_gnt,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_vld,
  output logic [CH_W-1:0]          rd_ch,
  input  logic                     hpb_wr_req,
  output logic                     hpb_wr_rdy,
  input  logic [ADDR_W-1:0]        hpb_wr_addr,
  input  logic [DATA_W-1:0]        hpb_wr_data,
  input  logic [BE_W-1:0]          hpb_wr_be,
  output logic                     rcb_wr_done,
  output logic [LVL_W-1:0]         wq_level,
  output logic                     wq_empty
);

  localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
  localparam int unsigned SC_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] r_wq_addr [WQ_DEPTH];
  logic [DATA_W-1:0] r_wq_data [WQ_DEPTH];
  logic [BE_W-1:0]   r_wq_be   [WQ_DEPTH];

  logic [PTR_W-1:0]  r_wq_wptr, r_wq_rptr;
  logic [LVL_W-1:0]  r_wq_level;
  logic [SC_W-1:0]   r_starve;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] r_ram_q;
  logic              r_p1_vld;
  logic [CH_W-1:0]   r_p1_ch;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_vld;
  logic [CH_W-1:0]   r_rd_ch;
  logic              r_wr_done;

  logic              w_full, w_empty, w_push, w_force, w_any_req, w_rd, w_wr;
  logic              w_gnt_found;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W:0]     w_scan;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_empty   = (r_wq_level == '0);
  assign w_full    = (r_wq_level == LVL_W'(WQ_DEPTH));
  // Ready ignores a same-cycle pop: no push-through when full.
  assign hpb_wr_rdy = !reset && !w_full;
  assign w_push    = hpb_wr_req && hpb_wr_rdy;
  assign w_any_req = |rd_req;
  assign w_force   = (STARVE_LIM != 0) && (r_starve == SC_W'(STARVE_LIM)) && !w_empty;
  assign w_rd      = !reset && w_any_req && !w_force;
  assign w_wr      = !reset && !w_empty && (w_force || !w_any_req);

  // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_RD.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
      if (w_scan >= (CH_W+1)'(NUM_RD)) w_scan = w_scan - (CH_W+1)'(NUM_RD);
      if (!w_gnt_found && rd_req[w_scan[CH_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan[CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_rd_addr = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (w_gnt_idx == CH_W'(k)) w_rd_addr = rd_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign rd_gnt = w_rd ? (NUM_RD'(1) << w_gnt_idx) : '0;

  // The single RAM port: either a byte-masked write or a read per cycle.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (r_wq_be[r_wq_rptr][b]) begin
          r_mem[r_wq_addr[r_wq_rptr]][b*8 +: 8] <= r_wq_data[r_wq_rptr][b*8 +: 8];
        end
      end
    end else if (w_rd) begin
      r_ram_q <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wq_addr[r_wq_wptr] <= hpb_wr_addr;
      r_wq_data[r_wq_wptr] <= hpb_wr_data;
      r_wq_be[r_wq_wptr]   <= hpb_wr_be;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wq_wptr  <= '0;
      r_wq_rptr  <= '0;
      r_wq_level <= '0;
      r_starve   <= '0;
      r_rr_ptr   <= '0;
      r_p1_vld   <= 1'b0;
      r_p1_ch    <= '0;
      r_rd_data  <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_ch    <= '0;
      r_wr_done  <= 1'b0;
    end else begin
      if (w_push) r_wq_wptr <= r_wq_wptr + 1'b1;
      if (w_wr)   r_wq_rptr <= r_wq_rptr + 1'b1;
      if (w_push && !w_wr)      r_wq_level <= r_wq_level + LVL_W'(1);
      else if (!w_push && w_wr) r_wq_level <= r_wq_level - LVL_W'(1);

      if (w_wr) begin
        r_starve <= '0;
      end else if (w_rd && !w_empty && (r_starve != SC_W'(STARVE_LIM))) begin
        r_starve <= r_starve + SC_W'(1);
      end

      if (w_rd) begin
        r_rr_ptr <= (w_gnt_idx == CH_W'(NUM_RD - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_p1_ch  <= w_gnt_idx;
      end
      r_p1_vld <= w_rd;

      r_rd_vld <= r_p1_vld;
      if (r_p1_vld) begin
        r_rd_data <= r_ram_q;
        r_rd_ch   <= r_p1_ch;
      end
      r_wr_done <= w_wr;
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_vld      = r_rd_vld;
  assign rd_ch       = r_rd_ch;
  assign rcb_wr_done = r_wr_done;
  assign wq_level    = r_wq_level;
  assign wq_empty    = w_empty;

endmodule

// File: tb/tb_rcb_mp.sv
// Bench for rcb_mp: directed vectors, read responses checked by a scoreboard monitor.
// u_dut forces writes after 16 starved cycles; u_dut0 never forces.
module tb_rcb_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rd_req = '0;
  logic [27:0] rd_addr = '0;
  logic        hpb_wr_req = 1'b0;
  logic [13:0] hpb_wr_addr = '0;
  logic [63:0] hpb_wr_data = '0;
  logic [7:0]  hpb_wr_be = '0;

  logic [1:0]  rd_gnt, d0_rd_gnt;
  logic [63:0] rd_data, d0_rd_data;
  logic        rd_vld, d0_rd_vld;
  logic        rd_ch, d0_rd_ch;
  logic        hpb_wr_rdy, d0_hpb_wr_rdy;
  logic        rcb_wr_done, d0_rcb_wr_done;
  logic [3:0]  wq_level, d0_wq_level;
  logic        wq_empty, d0_wq_empty;

  always #5 clk = ~clk;

  rcb_mp #(.DATA_W(64), .ADDR_W(14), .NUM_RD(2), .WQ_DEPTH(8), .STARVE_LIM(16)) u_dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_ch(rd_ch), .hpb_wr_req(hpb_wr_req),
    .hpb_wr_rdy(hpb_wr_rdy), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
    .hpb_wr_be(hpb_wr_be), .rcb_wr_done(rcb_wr_done), .wq_level(wq_level),
    .wq_empty(wq_empty)
  );

  rcb_mp #(.DATA_W(64), .ADDR_W(14), .NUM_RD(2), .WQ_DEPTH(8), .STARVE_LIM(0)) u_dut0 (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(d0_rd_gnt),
    .rd_data(d0_rd_data), .rd_vld(d0_rd_vld), .rd_ch(d0_rd_ch), .hpb_wr_req(hpb_wr_req),
    .hpb_wr_rdy(d0_hpb_wr_rdy), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
    .hpb_wr_be(hpb_wr_be), .rcb_wr_done(d0_rcb_wr_done), .wq_level(d0_wq_level),
    .wq_empty(d0_wq_empty)
  );

  typedef struct {
    logic [63:0] data;
    int          ch;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] mem_model [int];
  int n_chk = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, done0_cnt = 0, exp_ptr = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_vld) begin
        if (sb_q.size() == 0) begin
          chk("rd_vld_spurious", 64'(rd_vld), 64'd0);
        end else begin
          chk("rd_data", rd_data, sb_q[0].data);
          chk("rd_ch", 64'(rd_ch), 64'(sb_q[0].ch));
          chk("rd_latency", 64'(cyc), 64'(sb_q[0].due));
          sb_q.delete(0);
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        chk("rd_vld_missing", 64'(rd_vld), 64'd1);
        sb_q.delete(0);
      end
      if (rcb_wr_done) done_cnt++;
      if (d0_rcb_wr_done) done0_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks u_dut's grant against a round-robin model and queues the expected response.
  task automatic step_reads(input bit forced);
    logic [1:0]  eg;
    logic [13:0] a;
    int          ch;
    @(negedge clk);
    eg = '0;
    ch = -1;
    if (!forced) begin
      for (int k = 0; k < 2; k++) begin
        int c;
        c = (exp_ptr + k) % 2;
        if (ch < 0 && rd_req[c]) ch = c;
      end
    end
    if (ch >= 0) eg[ch] = 1'b1;
    chk("rd_gnt", 64'(rd_gnt), 64'(eg));
    if (ch >= 0) begin
      a = rd_addr[ch*14 +: 14];
      sb_q.push_back('{data: mem_model[int'(a)], ch: ch, due: cyc + 2});
      exp_ptr = (ch + 1) % 2;
    end
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_rd_gnt", 64'(rd_gnt), 64'd0);
    chk("rst_rd_vld", 64'(rd_vld), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_ch", 64'(rd_ch), 64'd0);
    chk("rst_wr_done", 64'(rcb_wr_done), 64'd0);
    chk("rst_wq_level", 64'(wq_level), 64'd0);
    chk("rst_wq_empty", 64'(wq_empty), 64'd1);
    chk("rst_wr_rdy", 64'(hpb_wr_rdy), 64'd0);
    chk("rst_d0_wq_level", 64'(d0_wq_level), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved, n;
    // Reset with requests pending: grants must stay low.
    rd_req = 2'b11;
    repeat (2) @(posedge clk);
    check_reset_state();
    tick();
    rd_req = '0;
    reset  = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", 64'(hpb_wr_rdy), 64'd1);

    // Full-word write, commit, then read back.
    tick();
    hpb_wr_req = 1'b1; hpb_wr_addr = 14'h0010;
    hpb_wr_data = 64'h1122334455667788; hpb_wr_be = 8'hFF;
    step_reads(1'b0);
    chk("a_rdy", 64'(hpb_wr_rdy), 64'd1);
    tick();
    hpb_wr_req = 1'b0;
    step_reads(1'b0);
    chk("a_level1", 64'(wq_level), 64'd1);
    chk("a_not_empty", 64'(wq_empty), 64'd0);
    mem_model[16] = 64'h1122334455667788;
    tick();
    rd_req = 2'b01; rd_addr = {14'h0000, 14'h0010};
    step_reads(1'b0);
    chk("a_done", 64'(rcb_wr_done), 64'd1);
    chk("a_level0", 64'(wq_level), 64'd0);
    tick();
    rd_req = '0;
    step_reads(1'b0);

    // Partial write over it, plus a second word; simultaneous push/pop.
    tick();
    hpb_wr_req = 1'b1; hpb_wr_addr = 14'h0010;
    hpb_wr_data = 64'hFFFFFFFFFFFFFFFF; hpb_wr_be = 8'h0F;
    step_reads(1'b0);
    tick();
    hpb_wr_addr = 14'h0020; hpb_wr_data = 64'hCAFEBABEDEADBEEF; hpb_wr_be = 8'hFF;
    step_reads(1'b0);
    chk("b_level_c1", 64'(wq_level), 64'd1);
    tick();
    hpb_wr_req = 1'b0;
    step_reads(1'b0);
    chk("b_level_pushpop", 64'(wq_level), 64'd1);
    mem_model[16] = 64'h11223344FFFFFFFF;
    mem_model[32] = 64'hCAFEBABEDEADBEEF;
    tick();
    rd_req = 2'b10; rd_addr = {14'h0010, 14'h0020};
    step_reads(1'b0);
    chk("b_level0", 64'(wq_level), 64'd0);
    tick();
    rd_req = '0;
    step_reads(1'b0);

    // Both channels requesting: strict alternation starting at ch0.
    rd_addr = {14'h0020, 14'h0010};
    for (int i = 0; i < 6; i++) begin
      tick();
      rd_req = 2'b11;
      step_reads(1'b0);
      chk("c_rr_seq", 64'(rd_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      rd_req = '0;
      step_reads(1'b0);
    end
    chk("done_cnt_ab", 64'(done_cnt), 64'd3);

    // One queued write under continuous reads: 16 grants, then a forced write.
    tick();
    rd_req = 2'b11;
    hpb_wr_req = 1'b1; hpb_wr_addr = 14'h0030;
    hpb_wr_data = 64'h0123456789ABCDEF; hpb_wr_be = 8'hFF;
    step_reads(1'b0);
    for (int k = 1; k < 20; k++) begin
      tick();
      hpb_wr_req = 1'b0;
      step_reads(k == 17);
      if (k == 18) chk("d_forced_done", 64'(rcb_wr_done), 64'd1);
    end
    mem_model[48] = 64'h0123456789ABCDEF;
    chk("done_cnt_d", 64'(done_cnt), 64'd4);

    // Three queued writes and reads in flight, then reset.
    for (int k = 0; k < 3; k++) begin
      tick();
      hpb_wr_req = 1'b1; hpb_wr_addr = 14'h0040 + 14'(k);
      hpb_wr_data = 64'(k); hpb_wr_be = 8'hFF;
      step_reads(1'b0);
      chk("f_level", 64'(wq_level), 64'(k));
    end
    tick();
    reset = 1'b1;
    hpb_wr_req = 1'b0;
    sb_q.delete();
    exp_ptr = 0;
    saved = done_cnt;
    check_reset_state();
    tick();
    rd_req = '0;
    reset = 1'b0;
    @(negedge clk);
    chk("f_rdy", 64'(hpb_wr_rdy), 64'd1);
    chk("f_level_after", 64'(wq_level), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      step_reads(1'b0);
    end
    chk("f_no_done", 64'(done_cnt), 64'(saved));

    // Fill u_dut0's queue under continuous reads; the ninth write must wait.
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      rd_req = 2'b11;
      hpb_wr_req = 1'b1; hpb_wr_addr = 14'h0100 + 14'(n);
      hpb_wr_data = 64'(n); hpb_wr_be = 8'hFF;
      step_reads(1'b0);
      chk("e_d0_level", 64'(d0_wq_level), (k < 8) ? 64'(k) : 64'd8);
      chk("e_d0_rdy", 64'(d0_hpb_wr_rdy), (k < 8) ? 64'd1 : 64'd0);
      if (k < 8) n++;
    end
    tick();
    rd_req = '0;
    hpb_wr_req = 1'b0;
    saved = done0_cnt;
    for (int i = 0; i < 12; i++) begin
      step_reads(1'b0);
      tick();
    end
    chk("e_d0_drain_done", 64'(done0_cnt - saved), 64'd8);
    chk("e_d0_level0", 64'(d0_wq_level), 64'd0);
    chk("e_d0_empty", 64'(d0_wq_empty), 64'd1);

    repeat (3) tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
